// File: rtl/demux14_router.sv
// demux14_router: 1-to-4 word router with a one-word valid/ready register per channel
// Ports: clk, rst_n (async active-low); din/in_valid/in_ready with select {s0,s1};
// y0..y3 with yk_valid/yk_ready per channel.
// With DEMUX14_CNT_EN defined, cnt0..cnt3 count accepts per channel (8-bit, wrapping).
module demux14_router (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       s0,
  input  logic       s1,
  output logic [7:0] y0,
  output logic [7:0] y1,
  output logic [7:0] y2,
  output logic [7:0] y3,
  output logic       y0_valid,
  output logic       y1_valid,
  output logic       y2_valid,
  input  logic       y0_ready,
  input  logic       y1_ready,
  input  logic       y2_ready,
  input  logic       y3_ready,
`ifdef DEMUX14_CNT_EN
  output logic [7:0] cnt0,
  output logic [7:0] cnt1,
  output logic [7:0] cnt2,
  output logic [7:0] cnt3,
`endif
  output logic       y3_valid
);
  logic [1:0]      k;
  logic [3:0]      v, rdy;
  logic [3:0][7:0] d;
  logic            acc;
  assign k        = {s0, s1};
  assign rdy      = {y3_ready, y2_ready, y1_ready, y0_ready};
  // a FULL channel can still accept when it is being drained in the same cycle
  assign in_ready = !v[k] || rdy[k];
  assign acc      = in_valid && in_ready;
  assign {y3, y2, y1, y0} = d;
  assign {y3_valid, y2_valid, y1_valid, y0_valid} = v;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      d <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (acc && k == 2'(i)) begin
          d[i] <= din;
          v[i] <= 1'b1;
        end else if (v[i] && rdy[i]) v[i] <= 1'b0;
    end
`ifdef DEMUX14_CNT_EN
  logic [3:0][7:0] c;
  assign {cnt3, cnt2, cnt1, cnt0} = c;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) c <= '0;
    else if (acc) c[k] <= c[k] + 8'd1;
`endif
endmodule

// File: tb/tb_demux14_router.sv
// tb_demux14_router: directed and randomized self-checking bench for demux14_router
module tb_demux14_router;
  logic       clk = 0, rst_n = 0, in_valid = 0, in_ready;
  logic [7:0] din = 0;
  logic [1:0] sel = 0;
  logic [3:0] rdy = 4'hF;
  logic [7:0] y0, y1, y2, y3;
  logic       y0_valid, y1_valid, y2_valid, y3_valid;
  logic [3:0][7:0] ys;
  logic [3:0] vs;
  int checks = 0, failures = 0, n_acc = 0, n_drn = 0;
`ifdef DEMUX14_CNT_EN
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
`endif
  always #5 clk = ~clk;
  demux14_router dut (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .s0(sel[1]), .s1(sel[0]),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .y0_valid(y0_valid), .y1_valid(y1_valid), .y2_valid(y2_valid),
    .y0_ready(rdy[0]), .y1_ready(rdy[1]), .y2_ready(rdy[2]), .y3_ready(rdy[3]),
`ifdef DEMUX14_CNT_EN
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
`endif
    .y3_valid(y3_valid)
  );
  assign ys = {y3, y2, y1, y0};
  assign vs = {y3_valid, y2_valid, y1_valid, y0_valid};
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask
  // reference: each channel is a one-word slot; a word goes in when the slot is
  // empty or leaving this cycle, and leaves when the consumer is ready
  logic [3:0]      m_v;
  logic [3:0][7:0] m_d;
  function automatic logic m_ready();
    return !m_v[sel] || rdy[sel];
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_v <= '0;
      m_d <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (in_valid && m_ready() && sel == 2'(i)) begin
          m_d[i] <= din;
          m_v[i] <= 1'b1;
        end else if (rdy[i]) m_v[i] <= 1'b0;
    end
  always @(posedge clk)
    if (rst_n) begin
      if (in_valid && in_ready) n_acc++;
      for (int i = 0; i < 4; i++) if (vs[i] && rdy[i]) n_drn++;
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("in_ready", int'(in_ready), int'(m_ready()));
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("y%0d_valid", i), int'(vs[i]), int'(m_v[i]));
        chk($sformatf("y%0d", i), int'(ys[i]), int'(m_d[i]));
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic snd(input logic [1:0] s, input logic [7:0] w);
    in_valid = 1;
    sel = s;
    din = w;
    step();
  endtask
  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    chk("reset_valids", int'(vs), 0);
    chk("reset_data", int'(ys), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    rst_n = 1;
  endtask
  initial begin
    do_reset();
    // routing
    rdy = 4'hF;
    for (int i = 0; i < 4; i++) begin
      snd(2'(i), 8'hA0 + 8'(i));
      chk("route_data", int'(ys[i]), 'hA0 + i);
      chk("route_valid", int'(vs), 1 << i);
    end
    in_valid = 0;
    step();
    chk("route_done", int'(vs), 0);
    // backpressure
    rdy = 4'b1011;
    snd(2, 8'h55);
    chk("bp_first", int'(y2), 'h55);
    din = 8'h66;
    #1 chk("bp_in_ready_low", int'(in_ready), 0);
    step();
    chk("bp_hold", int'(y2), 'h55);
    chk("bp_hold_valid", int'(y2_valid), 1);
    rdy = 4'hF;
    #1 chk("bp_in_ready_high", int'(in_ready), 1);
    step();
    chk("bp_second", int'(y2), 'h66);
    chk("bp_second_valid", int'(y2_valid), 1);
    in_valid = 0;
    step();
    chk("bp_drained", int'(y2_valid), 0);
    // independent drain
    rdy = 4'b0101;
    snd(1, 8'h11);
    snd(3, 8'h77);
    chk("ind_y3", int'(y3), 'h77);
    chk("ind_y3_valid", int'(y3_valid), 1);
    chk("ind_y1", int'(y1), 'h11);
    chk("ind_y1_valid", int'(y1_valid), 1);
    in_valid = 0;
    rdy = 4'hF;
    step();
    // reset mid-operation
    rdy = 4'b1010;
    snd(0, 8'h10);
    snd(2, 8'h20);
    in_valid = 0;
    chk("pre_rst_valids", int'(vs), 'b0101);
    rst_n = 0;
    #1;
    chk("mid_rst_valids", int'(vs), 0);
    chk("mid_rst_data", int'(ys), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    #2 rst_n = 1;
    step();
    // throughput
    rdy = 4'hF;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1;
      sel = 0;
      din = 8'(i * 13 + 5);
      #1 chk("tp_in_ready", int'(in_ready), 1);
      step();
      chk("tp_word", int'(y0), (i * 13 + 5) & 'hFF);
      chk("tp_valid", int'(y0_valid), 1);
    end
    in_valid = 0;
    step();
`ifdef DEMUX14_CNT_EN
    do_reset();
    for (int i = 0; i < 257; i++) snd(1, 8'(i));
    in_valid = 0;
    chk("cnt0", int'(cnt0), 0);
    chk("cnt1", int'(cnt1), 1);
    chk("cnt2", int'(cnt2), 0);
    chk("cnt3", int'(cnt3), 0);
`endif
    // randomized traffic
    do_reset();
    n_acc = 0;
    n_drn = 0;
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom);
      sel = 2'($urandom);
      din = 8'($urandom);
      rdy = 4'($urandom) | 4'($urandom);
      step();
    end
    in_valid = 0;
    rdy = 0;
    step();
    chk("conservation", n_acc, n_drn + $countones(vs));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
